// File: rtl/pulse_cmd_parser_if.sv
// UART-side byte stream (RX bytes in, ACK/NAK bytes out) between the UART and pulse_cmd_parser.
// master = UART side, slave = parser side.
interface pulse_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output rx_data, output rx_valid, output tx_ready, input tx_data, input tx_valid);
  modport slave  (input rx_data, input rx_valid, input tx_ready, output tx_data, output tx_valid);
endinterface

// File: rtl/pulse_cmd_parser.sv
// Framed XOR-checksummed command parser that commits pulse parameters atomically.
// Optional ACK/NAK reply on the tx side is enabled by defining PARSER_ACK_EN.
module pulse_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 120000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  DEF_PER        = 8'd10,
  parameter logic [15:0] DEF_WID        = 16'd30,
  parameter logic [15:0] DEF_DEL        = 16'd200
) (
  input  logic                 clk,
  input  logic                 resetn,
  pulse_cmd_parser_if.slave    bus,
  output logic [7:0]           per,
  output logic [15:0]          p1wid,
  output logic [15:0]          del,
  output logic [15:0]          p2wid,
  output logic [7:0]           p_bl,
  output logic                 pu,
  output logic                 cp,
  output logic                 bl,
  output logic                 rxd,
  output logic                 frame_err
);
  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_COMMIT} state_e;

  localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT_CYCLES);
  localparam logic [16:0] TMR_MAX   = 17'h1FFFF;
  localparam logic [7:0]  ACK_BYTE  = 8'h06;
  localparam logic [7:0]  NAK_BYTE  = 8'h15;

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      csum_q, csum_d;
  logic [7:0][7:0] shadow_q, shadow_d;
  logic [2:0]      flag_q, flag_d;
  logic [16:0]     tmr_q, tmr_d;
  logic [7:0]      per_q, per_d, p_bl_q, p_bl_d;
  logic [15:0]     p1wid_q, p1wid_d, del_q, del_d, p2wid_q, p2wid_d;
  logic [2:0]      mode_q, mode_d;
  logic            rxd_q, rxd_d, ferr_q, ferr_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            ack_s, nak_s;
  logic            sync_s, tmo_s, sum_ok_s;

  function automatic logic [16:0] sat_inc(input logic [16:0] v);
    if (v == TMR_MAX) sat_inc = v;
    else              sat_inc = v + 17'd1;
  endfunction

  assign sync_s   = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
  assign tmo_s    = !bus.rx_valid && (tmr_q >= TMO_LIMIT);
  assign sum_ok_s = (bus.rx_data == csum_q);

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_COMMIT: begin
        if (sync_s) state_d = S_PAYLOAD;
        else        state_d = S_IDLE;
      end
      S_PAYLOAD: begin
        if (bus.rx_valid && (idx_q == 4'd8)) state_d = S_CHECK;
        else if (tmo_s)                      state_d = S_IDLE;
        else                                 state_d = S_PAYLOAD;
      end
      S_CHECK: begin
        if (bus.rx_valid) state_d = sum_ok_s ? S_COMMIT : S_IDLE;
        else if (tmo_s)   state_d = S_IDLE;
        else              state_d = S_CHECK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: byte capture, checksum, gap timer and the atomic commit.
  always_comb begin
    idx_d    = idx_q;
    csum_d   = csum_q;
    shadow_d = shadow_q;
    flag_d   = flag_q;
    tmr_d    = tmr_q;
    per_d    = per_q;
    p1wid_d  = p1wid_q;
    del_d    = del_q;
    p2wid_d  = p2wid_q;
    p_bl_d   = p_bl_q;
    mode_d   = mode_q;
    rxd_d    = 1'b0;
    ferr_d   = 1'b0;
    ack_s    = 1'b0;
    nak_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmr_d = 17'd0;
        if (sync_s) begin
          idx_d  = 4'd0;
          csum_d = 8'h00;
        end else begin
          idx_d = idx_q;
        end
      end
      S_COMMIT: begin
        tmr_d   = 17'd0;
        per_d   = shadow_q[0];
        p1wid_d = {shadow_q[1], shadow_q[2]};
        del_d   = {shadow_q[3], shadow_q[4]};
        p2wid_d = {shadow_q[5], shadow_q[6]};
        p_bl_d  = shadow_q[7];
        mode_d  = flag_q;
        rxd_d   = 1'b1;
        ack_s   = 1'b1;
        if (sync_s) begin
          idx_d  = 4'd0;
          csum_d = 8'h00;
        end else begin
          idx_d = idx_q;
        end
      end
      S_PAYLOAD: begin
        if (bus.rx_valid) begin
          if (idx_q[3]) flag_d = bus.rx_data[2:0];
          else          shadow_d[idx_q[2:0]] = bus.rx_data;
          csum_d = csum_q ^ bus.rx_data;
          idx_d  = idx_q + 4'd1;
          tmr_d  = 17'd0;
        end else if (tmo_s) begin
          ferr_d = 1'b1;
          tmr_d  = 17'd0;
        end else begin
          tmr_d = sat_inc(tmr_q);
        end
      end
      S_CHECK: begin
        if (bus.rx_valid) begin
          tmr_d = 17'd0;
          if (!sum_ok_s) begin
            ferr_d = 1'b1;
            nak_s  = 1'b1;
          end else begin
            ferr_d = 1'b0;
          end
        end else if (tmo_s) begin
          ferr_d = 1'b1;
          tmr_d  = 17'd0;
        end else begin
          tmr_d = sat_inc(tmr_q);
        end
      end
      default: begin
        tmr_d = 17'd0;
        idx_d = 4'd0;
      end
    endcase
  end

`ifdef PARSER_ACK_EN
  // A fresh ACK/NAK always wins over the handshake drop, overwriting a pending byte.
  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (ack_s) begin
      tx_data_d  = ACK_BYTE;
      tx_valid_d = 1'b1;
    end else if (nak_s) begin
      tx_data_d  = NAK_BYTE;
      tx_valid_d = 1'b1;
    end else if (tx_valid_q && bus.tx_ready) begin
      tx_valid_d = 1'b0;
    end else begin
      tx_valid_d = tx_valid_q;
    end
  end
`else
  logic tx_ready_unused_s;
  assign tx_ready_unused_s = bus.tx_ready;
  assign tx_data_d  = 8'h00;
  assign tx_valid_d = 1'b0;
`endif

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx_q      <= 4'd0;
      csum_q     <= 8'h00;
      shadow_q   <= '0;
      flag_q     <= 3'd0;
      tmr_q      <= 17'd0;
      per_q      <= DEF_PER;
      p1wid_q    <= DEF_WID;
      del_q      <= DEF_DEL;
      p2wid_q    <= DEF_WID;
      p_bl_q     <= 8'd0;
      mode_q     <= 3'd0;
      rxd_q      <= 1'b0;
      ferr_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      shadow_q   <= shadow_d;
      flag_q     <= flag_d;
      tmr_q      <= tmr_d;
      per_q      <= per_d;
      p1wid_q    <= p1wid_d;
      del_q      <= del_d;
      p2wid_q    <= p2wid_d;
      p_bl_q     <= p_bl_d;
      mode_q     <= mode_d;
      rxd_q      <= rxd_d;
      ferr_q     <= ferr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign per          = per_q;
  assign p1wid        = p1wid_q;
  assign del          = del_q;
  assign p2wid        = p2wid_q;
  assign p_bl         = p_bl_q;
  assign pu           = mode_q[0];
  assign cp           = mode_q[1];
  assign bl           = mode_q[2];
  assign rxd          = rxd_q;
  assign frame_err    = ferr_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
endmodule
